// File: rtl/cpu_defs.sv
// cpu_defs: CSR snapshot and CSR exception-write types shared across the core.
//   crmd_t / prmd_t / ecfg_t  : architectural CSR field layouts
//   csr_t                     : read snapshot handed to consumers of CSR state
//   excp_wr_csr_req_t         : one-shot exception write into the CSR file
//   ecode_e                   : exception codes (interrupt = 0)
//   IS_*                      : bit positions inside ESTAT.IS
package cpu_defs;

    typedef struct packed {
        logic       pg;
        logic       da;
        logic       ie;
        logic [1:0] plv;
    } crmd_t;

    typedef struct packed {
        logic       pie;
        logic [1:0] pplv;
    } prmd_t;

    typedef struct packed {
        logic [12:0] lie;
    } ecfg_t;

    typedef struct packed {
        crmd_t       crmd;
        ecfg_t       ecfg;
        logic [31:0] eentry;
        logic [31:0] badv;
        logic [18:0] tlbehi_vppn;
    } csr_t;

    typedef struct packed {
        logic        we;
        crmd_t       crmd;
        prmd_t       prmd;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] era;
        logic [31:0] badv;
        logic [18:0] tlbehi_vppn;
    } excp_wr_csr_req_t;

    typedef enum logic [5:0] {
        ECODE_INT = 6'h00
    } ecode_e;

    localparam int IS_W      = 13;
    localparam int IS_SWI_LO = 0;
    localparam int IS_HWI_LO = 2;
    localparam int IS_TI     = 11;
    localparam int IS_IPI    = 12;

endpackage

// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: block-local constants and the helper that forms the CSR
// write performed on interrupt entry.
//   int_entry_req(csr, era, ecode) -> excp_wr_csr_req_t with we=1
package intr_ctrl_pkg;
    import cpu_defs::*;

    localparam logic [1:0] PLV_KERNEL = 2'd0;
    localparam int         HWI_N      = 8;

    // Enter kernel with interrupts masked; previous plv/ie are saved in prmd.
    // badv and tlbehi.vppn are rewritten with their current values so the
    // write port does not need per-field enables.
    function automatic excp_wr_csr_req_t int_entry_req(input csr_t        csr,
                                                       input logic [31:0] era,
                                                       input logic [5:0]  ecode);
        excp_wr_csr_req_t r;
        r             = '0;
        r.we          = 1'b1;
        r.crmd        = csr.crmd;
        r.crmd.plv    = PLV_KERNEL;
        r.crmd.ie     = 1'b0;
        r.prmd.pplv   = csr.crmd.plv;
        r.prmd.pie    = csr.crmd.ie;
        r.ecode       = ecode;
        r.esubcode    = '0;
        r.era         = era;
        r.badv        = csr.badv;
        r.tlbehi_vppn = csr.tlbehi_vppn;
        return r;
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: commit, CSR and fetch-redirect signals of the interrupt
// controller.
//   master (controller): in  csr_rd, excp_busy, int_ack, ack_pc, redirect_ready
//                        out is, int_req, excp_wr_req, redirect_valid,
//                            redirect_pc, fsm_state (debug view of the FSM)
//   slave  (core side) : the reverse directions
//
// Handshakes: int_req/int_ack and redirect_valid/redirect_ready are
// valid/ready pairs. A transfer happens on a rising edge where both are high.
// The controller may withdraw int_req before an ack (the interrupt went
// away); redirect_valid and redirect_pc are held stable until accepted.
// excp_wr_req.we is a single-cycle strobe with no back-pressure.
interface intr_ctrl_if;
    import cpu_defs::*;

    csr_t             csr_rd;
    logic             excp_busy;
    logic [IS_W-1:0]  is;
    logic             int_req;
    logic             int_ack;
    logic [31:0]      ack_pc;
    excp_wr_csr_req_t excp_wr_req;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ready;
    logic [1:0]       fsm_state;

    modport master (
        input  csr_rd, excp_busy, int_ack, ack_pc, redirect_ready,
        output is, int_req, excp_wr_req, redirect_valid, redirect_pc, fsm_state
    );

    modport slave (
        output csr_rd, excp_busy, int_ack, ack_pc, redirect_ready,
        input  is, int_req, excp_wr_req, redirect_valid, redirect_pc, fsm_state
    );

endinterface

// File: rtl/intr_ctrl_sync.sv
// intr_sync: N-bit multi-flop synchronizer for asynchronous level inputs.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   d        : asynchronous input bits
//   q        : d delayed by STAGES flops (STAGES below 2 is raised to 2)
module intr_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: owns ESTAT.IS and sequences interrupt entry.
//   clk, rst       : clock, synchronous active-high reset
//   hw_int[7:0]    : asynchronous external lines -> IS[9:2] after sync
//   swi/swi_clr    : set/clear pulses for IS[1:0] (set wins)
//   ti/ti_clr      : timer level / clear pulse for IS[11] (set wins)
//   bus (master)   : CSR snapshot and exception write, commit handshake,
//                    fetch redirect (see intr_ctrl_if)
//   int_lat        : only with INTR_CTRL_LAT_CNT_EN defined; cycles from
//                    int_req assertion to redirect acceptance of the last
//                    completed entry
// Sequence: IDLE -> REQ (int_req) -> WRITE (one CSR write strobe)
//           -> REDIRECT (fetch to EENTRY) -> IDLE.
module intr_ctrl
    import cpu_defs::*, intr_ctrl_pkg::*;
#(
    parameter int         HWI_SYNC_STAGES = 2,
    parameter logic [5:0] INT_ECODE       = ECODE_INT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [HWI_N-1:0] hw_int,
    input  logic [1:0]       swi,
    input  logic [1:0]       swi_clr,
    input  logic             ti,
    input  logic             ti_clr,
    intr_ctrl_if.master      bus
`ifdef INTR_CTRL_LAT_CNT_EN
    ,
    output logic [31:0]      int_lat
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WRITE    = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IS_W-1:0]  is_q, is_d;
    logic             int_req_q, int_req_d;
    logic             we_q, we_d;
    logic             redir_v_q, redir_v_d;
    logic [31:0]      era_q, era_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic [HWI_N-1:0] hwi_sync;
    logic             take;
    excp_wr_csr_req_t wr_req;

    intr_sync #(
        .WIDTH  (HWI_N),
        .STAGES (HWI_SYNC_STAGES)
    ) u_hwi_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (hwi_sync)
    );

    // Pending vector. Hardware lines are level-sensitive (not latched);
    // software and timer bits are sticky with set taking priority.
    always_comb begin
        is_d = '0;
        for (int i = 0; i < 2; i++) begin
            is_d[IS_SWI_LO+i] = swi[i] | (is_q[IS_SWI_LO+i] & ~swi_clr[i]);
        end
        is_d[IS_HWI_LO +: HWI_N] = hwi_sync;
        is_d[IS_TI]              = ti | (is_q[IS_TI] & ~ti_clr);
        is_d[IS_IPI]             = 1'b0;
    end

    assign take = bus.csr_rd.crmd.ie
                & (|(is_q & bus.csr_rd.ecfg.lie))
                & ~bus.excp_busy;

    always_comb begin
        state_d    = state_q;
        era_d      = era_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the same edge the interrupt vanishes is still
                // honoured: commit has already squashed the instruction.
                if (bus.int_ack) begin
                    era_d   = bus.ack_pc;
                    state_d = S_WRITE;
                end else if (!take) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                redir_pc_d = {bus.csr_rd.eentry[31:6], 6'b0};
                state_d    = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Handshake outputs are flops decoded from the next state, which
        // keeps them glitch-free and mutually exclusive.
        int_req_d = (state_d == S_REQ);
        we_d      = (state_d == S_WRITE);
        redir_v_d = (state_d == S_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_q       <= '0;
            int_req_q  <= 1'b0;
            we_q       <= 1'b0;
            redir_v_q  <= 1'b0;
            era_q      <= '0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            is_q       <= is_d;
            int_req_q  <= int_req_d;
            we_q       <= we_d;
            redir_v_q  <= redir_v_d;
            era_q      <= era_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Payload is only driven while the strobe is up so an idle write port
    // reads as all zeros.
    always_comb begin
        wr_req = '0;
        if (we_q) begin
            wr_req = int_entry_req(bus.csr_rd, era_q, INT_ECODE);
        end
    end

    assign bus.is             = is_q;
    assign bus.int_req        = int_req_q;
    assign bus.excp_wr_req    = wr_req;
    assign bus.redirect_valid = redir_v_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.fsm_state      = state_q;

`ifdef INTR_CTRL_LAT_CNT_EN
    logic [31:0] lat_cnt_q, lat_cnt_d;
    logic [31:0] int_lat_q, int_lat_d;

    // Counter reads 0 in the first REQ cycle and counts every cycle until
    // the redirect is accepted; that final value is published.
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        int_lat_d = int_lat_q;
        if (state_q == S_IDLE) begin
            if (state_d == S_REQ) begin
                lat_cnt_d = '0;
            end
        end else begin
            lat_cnt_d = lat_cnt_q + 32'd1;
        end
        if (state_q == S_REDIRECT && bus.redirect_ready) begin
            int_lat_d = lat_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt_q <= '0;
            int_lat_q <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            int_lat_q <= int_lat_d;
        end
    end

    assign int_lat = int_lat_q;
`endif

endmodule
